// File: rtl/bist_tpg.sv
// 4-bit LFSR test pattern generator with valid/ready handoff to the CUT/ORA side.
// Define BIST_TPG_ZERO_EN to extend the sequence to all 16 values (0000 inserted after 1000).
module bist_tpg #(
  parameter logic [3:0] SEED         = 4'b0001,
  parameter int         NUM_PATTERNS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       pattern_ready,
  output logic [3:0] pattern_out,
  output logic       pattern_valid,
  output logic [4:0] pattern_index,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

`ifdef BIST_TPG_ZERO_EN
  localparam logic [3:0] SEED_EFF = SEED;
`else
  localparam logic [3:0] SEED_EFF = (SEED == 4'b0000) ? 4'b0001 : SEED;
`endif
  localparam logic [4:0] LAST_IDX = 5'(NUM_PATTERNS - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_lfsr,  w_lfsr_nxt;
  logic [4:0]  r_count, w_count_nxt;
  logic [3:0]  w_lfsr_step;
  logic        w_fb;
  logic        w_xfer;

`ifdef BIST_TPG_ZERO_EN
  // Extra term flips feedback only for 1000 and 0000, splicing 0000 into the cycle.
  assign w_fb = r_lfsr[3] ^ r_lfsr[2] ^ (r_lfsr[2:0] == 3'b000);
`else
  assign w_fb = r_lfsr[3] ^ r_lfsr[2];
`endif
  assign w_lfsr_step = {r_lfsr[2:0], w_fb};
  assign w_xfer      = (r_state == S_RUN) && pattern_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_lfsr  <= 4'b0001;
      r_count <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_lfsr_nxt  = SEED_EFF;
          w_count_nxt = 5'd0;
        end
      end
      S_RUN: begin
        // Abort wins over a same-cycle transfer; that transfer is not counted.
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_xfer) begin
          w_lfsr_nxt  = w_lfsr_step;
          w_count_nxt = r_count + 5'd1;
          if (r_count == LAST_IDX) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (start) begin
          w_state_nxt = S_RUN;
          w_lfsr_nxt  = SEED_EFF;
          w_count_nxt = 5'd0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign pattern_out   = r_lfsr;
  assign pattern_valid = (r_state == S_RUN);
  assign busy          = (r_state == S_RUN);
  assign done          = (r_state == S_DONE);
  assign pattern_index = r_count;

endmodule

// File: tb/tb_bist_tpg.sv
// Directed bench for bist_tpg: full runs, ready throttling, abort, reset mid-run, rerun from DONE.
module tb_bist_tpg;

`ifdef BIST_TPG_ZERO_EN
  localparam int NP = 16;
`else
  localparam int NP = 15;
`endif

  logic       clk = 1'b0;
  logic       reset, start, abort, pattern_ready;
  logic [3:0] pattern_out;
  logic       pattern_valid, busy, done;
  logic [4:0] pattern_index;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0] exp_seq [0:15];

  bist_tpg #(.SEED(4'b0001), .NUM_PATTERNS(NP)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern_ready(pattern_ready), .pattern_out(pattern_out),
    .pattern_valid(pattern_valid), .pattern_index(pattern_index),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    exp_seq[0]  = 4'b0001; exp_seq[1]  = 4'b0010; exp_seq[2]  = 4'b0100; exp_seq[3]  = 4'b1001;
    exp_seq[4]  = 4'b0011; exp_seq[5]  = 4'b0110; exp_seq[6]  = 4'b1101; exp_seq[7]  = 4'b1010;
    exp_seq[8]  = 4'b0101; exp_seq[9]  = 4'b1011; exp_seq[10] = 4'b0111; exp_seq[11] = 4'b1111;
    exp_seq[12] = 4'b1110; exp_seq[13] = 4'b1100; exp_seq[14] = 4'b1000; exp_seq[15] = 4'b0000;

    reset = 1'b1; start = 1'b0; abort = 1'b0; pattern_ready = 1'b0;
    tick(); tick();
    check("rst_pattern", 32'(pattern_out), 32'h1);
    check("rst_valid",   32'(pattern_valid), 32'h0);
    check("rst_index",   32'(pattern_index), 32'h0);
    check("rst_busy",    32'(busy), 32'h0);
    check("rst_done",    32'(done), 32'h0);

    // Full run with ready held high
    reset = 1'b0; start = 1'b1; pattern_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < NP; i++) begin
      check($sformatf("run_pat%0d", i), 32'(pattern_out), 32'(exp_seq[i]));
      check($sformatf("run_idx%0d", i), 32'(pattern_index), i);
      check($sformatf("run_vld%0d", i), 32'({pattern_valid, busy, done}), 32'b110);
      tick();
    end
    check("run_done",      32'({pattern_valid, busy, done}), 32'b001);
    check("run_done_idx",  32'(pattern_index), NP);
    tick();
    check("done_hold",     32'(done), 32'h1);

    // Start held in DONE reruns immediately; start in RUN ignored
    pattern_ready = 1'b0; start = 1'b1;
    tick();
    check("rerun_pat",  32'(pattern_out), 32'h1);
    check("rerun_idx",  32'(pattern_index), 32'h0);
    check("rerun_done", 32'({busy, done}), 32'b10);
    tick();
    start = 1'b0;
    check("start_in_run_ignored", 32'({pattern_out, pattern_index}), 32'({4'h1, 5'd0}));

    // Ready toggling: each pattern held for a stalled cycle, then transferred
    begin
      int cyc = 0;
      for (int i = 0; i < NP; i++) begin
        pattern_ready = 1'b0;
        tick(); cyc++;
        check($sformatf("tog_stable%0d", i), 32'(pattern_out), 32'(exp_seq[i]));
        check($sformatf("tog_idx%0d", i), 32'(pattern_index), i);
        pattern_ready = 1'b1;
        tick(); cyc++;
      end
      check("tog_done",   32'(done), 32'h1);
      check("tog_cycles", cyc, 2 * NP);
    end

    // Abort after 5 transfers, with a transfer offered in the same cycle
    start = 1'b1; pattern_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre_abort_idx", 32'(pattern_index), 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_state", 32'({pattern_valid, busy, done}), 32'b000);
    check("abort_idx",   32'(pattern_index), 32'd5);
    check("abort_pat",   32'(pattern_out), 32'(exp_seq[5]));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_pat", 32'(pattern_out), 32'h1);
    check("restart_idx", 32'(pattern_index), 32'h0);

    // Reset after 3 transfers, start asserted with it
    for (int i = 0; i < 3; i++) tick();
    check("pre_rst_idx", 32'(pattern_index), 32'd3);
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    check("midrst_pat",  32'(pattern_out), 32'h1);
    check("midrst_ctl",  32'({pattern_valid, busy, done}), 32'b000);
    check("midrst_idx",  32'(pattern_index), 32'h0);
    tick();
    check("midrst_idle", 32'({pattern_valid, busy, done}), 32'b000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
